mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D block-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I and D ports.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise D wins every tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic winner
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Winner for the current request pattern; a lone requester always wins.
  always_comb begin
    winner = PORT_I;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_grant == PORT_I) begin
        winner = PORT_D;
      end else begin
        winner = PORT_I;
      end
`else
      winner = PORT_D;
`endif
    end else if (d_req) begin
      winner = PORT_D;
    end else begin
      winner = PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of one 128-bit block memory port.
// Build with ARB_ROUND_ROBIN_EN defined for round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t state;
  state_t next_state;
  logic   grant;
  logic   last_grant;
  logic   i_req;
  logic   d_req;
  logic   winner;
  logic   done;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign done  = (state == S_BUSY) && mem_ready;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // State register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one transaction in flight, released by mem_ready.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (i_req || d_req) begin
          next_state = S_BUSY;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_BUSY;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Grant and memory-side registers; read+write on one port is issued as a write.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      grant      <= PORT_I;
      last_grant <= PORT_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            grant <= winner;
            if (winner == PORT_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_write <= d_write;
              mem_read  <= d_read & ~d_write;
            end else begin
              mem_addr  <= i_addr;
              mem_wdata <= i_wdata;
              mem_write <= i_write;
              mem_read  <= i_read & ~i_write;
            end
          end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= grant;
          end
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion strobes are combinational so the port sees mem_ready with no added delay.
  assign i_ready = done && (grant == PORT_I);
  assign d_ready = done && (grant == PORT_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand sequences for reset and ties.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] IWD = 128'h0000_1234_0000_5678_0000_9abc_0000_def0;
  localparam logic [DW-1:0] DW1 = 128'h1;
  localparam logic [DW-1:0] A5  = {16{8'hA5}};
  localparam logic [DW-1:0] C3  = {16{8'hC3}};
  localparam logic [DW-1:0] X5A = {16{8'h5A}};
  localparam logic [DW-1:0] X3C = {16{8'h3C}};
  localparam logic [DW-1:0] XFF = {16{8'hFF}};

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    logic          mrdy;
    logic [DW-1:0] mrd;
    logic          er, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic          eir, edr;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = IWD;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    logic [AW-1:0] tie_addr;
    logic [1:0]    exp_d;
    logic          seen;

    //        ir    iw    ia        dr    dw    da       dwd  mrdy  mrd  er    ew    ea        ewd  eir   edr
    vecs[0]  = '{1'b0, 1'b0, 28'h0,   1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b0, 1'b0, 28'h0,   '0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 28'h123, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b0, 1'b0, 28'h0,   '0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 28'h123, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b1, 1'b0, 28'h123, IWD, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 28'h123, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b1, 1'b0, 28'h123, IWD, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 28'h123, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b1, 1'b0, 28'h123, IWD, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 28'h123, 1'b0, 1'b0, 28'h0,  '0,  1'b1, A5,  1'b1, 1'b0, 28'h123, IWD, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 28'h0,   1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b0, 1'b0, 28'h123, IWD, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 28'h0,   1'b0, 1'b1, 28'h10, DW1, 1'b0, '0,  1'b0, 1'b0, 28'h123, IWD, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 28'h0,   1'b0, 1'b1, 28'h10, DW1, 1'b0, '0,  1'b0, 1'b1, 28'h10,  DW1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 28'h456, 1'b0, 1'b1, 28'h10, DW1, 1'b0, '0,  1'b0, 1'b1, 28'h10,  DW1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 28'h456, 1'b0, 1'b1, 28'h10, DW1, 1'b1, C3,  1'b0, 1'b1, 28'h10,  DW1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 28'h456, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b0, 1'b0, 28'h10,  DW1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 28'h456, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b1, 1'b0, 28'h456, IWD, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 28'h456, 1'b0, 1'b0, 28'h0,  '0,  1'b1, X5A, 1'b1, 1'b0, 28'h456, IWD, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 28'h789, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b0, 1'b0, 28'h456, IWD, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 28'h789, 1'b0, 1'b0, 28'h0,  '0,  1'b0, '0,  1'b0, 1'b1, 28'h789, IWD, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 28'h789, 1'b0, 1'b0, 28'h0,  '0,  1'b1, X3C, 1'b0, 1'b1, 28'h789, IWD, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 28'h0,   1'b0, 1'b0, 28'h0,  '0,  1'b1, XFF, 1'b0, 1'b0, 28'h789, IWD, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 28'h0,   1'b0, 1'b0, 28'h0,  '0,  1'b1, XFF, 1'b0, 1'b0, 28'h789, IWD, 1'b0, 1'b0};

    idle_inputs();
    proc_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read",  {127'd0, mem_read},  '0);
    chk("rst_mem_write", {127'd0, mem_write}, '0);
    chk("rst_mem_addr",  {100'd0, mem_addr},  '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    proc_reset = 1'b0;

    // Each vector: inputs applied just after an edge, outputs sampled mid-cycle.
    for (int v = 0; v < 19; v++) begin
      @(posedge clk);
      #1;
      i_read = vecs[v].ir; i_write = vecs[v].iw; i_addr = vecs[v].ia;
      d_read = vecs[v].dr; d_write = vecs[v].dw; d_addr = vecs[v].da; d_wdata = vecs[v].dwd;
      mem_ready = vecs[v].mrdy; mem_rdata = vecs[v].mrd;
      #4;
      chk($sformatf("v%0d_mem_read", v),  {127'd0, mem_read},  {127'd0, vecs[v].er});
      chk($sformatf("v%0d_mem_write", v), {127'd0, mem_write}, {127'd0, vecs[v].ew});
      chk($sformatf("v%0d_mem_addr", v),  {100'd0, mem_addr},  {100'd0, vecs[v].ea});
      chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].ewd);
      chk($sformatf("v%0d_i_ready", v),   {127'd0, i_ready},   {127'd0, vecs[v].eir});
      chk($sformatf("v%0d_d_ready", v),   {127'd0, d_ready},   {127'd0, vecs[v].edr});
      if (vecs[v].eir) chk($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].mrd);
      if (vecs[v].edr) chk($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].mrd);
    end

    // Reset in the middle of a read: everything clears at once, no ready.
    @(posedge clk); #1;
    idle_inputs();
    i_read = 1'b1; i_addr = 28'hABC;
    @(posedge clk); #1;
    chk("mid_busy_mem_read", {127'd0, mem_read}, {127'd0, 1'b1});
    proc_reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("arst_mem_read", {127'd0, mem_read}, '0);
    chk("arst_mem_addr", {100'd0, mem_addr}, '0);
    chk("arst_i_ready",  {127'd0, i_ready},  '0);
    chk("arst_d_ready",  {127'd0, d_ready},  '0);
    @(posedge clk); #1;
    proc_reset = 1'b0; i_read = 1'b0;
    #1;
    chk("post_rst_i_ready", {127'd0, i_ready}, '0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("post_rst_idle_mem_read", {127'd0, mem_read}, '0);

    // Both ports requesting continuously for three transactions.
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 2'b10;
`else
    exp_d = 2'b00;
`endif
    i_read = 1'b1; i_addr = 28'hAAA;
    d_read = 1'b1; d_addr = 28'hDDD;
    for (int g = 0; g < 3; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        @(posedge clk); #1;
        seen = mem_read;
      end
      chk($sformatf("tie%0d_started", g), {127'd0, seen}, {127'd0, 1'b1});
      if (g == 1) tie_addr = exp_d[0] ? 28'hAAA : 28'hDDD;
      else        tie_addr = (g == 2) ? 28'hDDD : 28'hDDD;
      chk($sformatf("tie%0d_mem_addr", g), {100'd0, mem_addr}, {100'd0, tie_addr});
      mem_ready = 1'b1; mem_rdata = {120'd0, 8'(g)};
      #1;
      chk($sformatf("tie%0d_d_ready", g), {127'd0, d_ready}, {127'd0, tie_addr == 28'hDDD});
      chk($sformatf("tie%0d_i_ready", g), {127'd0, i_ready}, {127'd0, tie_addr == 28'hAAA});
      @(posedge clk); #1;
      mem_ready = 1'b0;
      exp_d = {1'b0, exp_d[1]};
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
